// File: rtl/cpu_pkg.sv
// Shared CPU/interrupt definitions: sequencer state encoding and the per-port
// interrupt vector addresses used by the interrupt manager.
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISR   = 2'd1,
    GUARD = 2'd2
  } irq_state_e;

  localparam logic [9:0] VEC_P0 = 10'd984;
  localparam logic [9:0] VEC_P1 = 10'd994;
  localparam logic [9:0] VEC_P2 = 10'd1004;
  localparam logic [9:0] VEC_P3 = 10'd1014;

endpackage

// File: rtl/irq_sequencer.sv
// CPU-side interrupt sequencer: redirects the PC to the vector, saves and
// restores the return address, and hands the fin pulse back to the manager.
module irq_sequencer
  import cpu_pkg::*;
#(
  parameter int unsigned PC_W      = 10,
  parameter int unsigned GUARD_CYC = 1,
  parameter int unsigned CNT_W     = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             s_interrup,
  input  logic [PC_W-1:0]  dir,
  input  logic             ie,
  input  logic [PC_W-1:0]  pc_next,
  input  logic             reti,
  output logic [PC_W-1:0]  pc_load,
  output logic             fin,
  output logic             in_isr,
  output logic [CNT_W-1:0] irq_count,
  output logic             err_spurious
);

  localparam logic [3:0] GUARD_INIT = 4'(GUARD_CYC);

  irq_state_e       state_q;
  logic [PC_W-1:0]  ret_pc_q;
  logic [3:0]       guard_cnt_q;
  logic [CNT_W-1:0] irq_count_q;
  logic             err_q;
  logic             take;

  // Redirect and fin are combinational so the vector/return address lands in
  // the PC register at the same edge; reset masks them so no fin escapes.
  always_comb begin
    take    = (state_q == IDLE) && s_interrup && ie && !reset;
    fin     = (state_q == ISR) && reti && !reset;
    in_isr  = (state_q == ISR) && !reset;
    pc_load = pc_next;
    if (take) begin
      pc_load = dir;
    end else if (fin) begin
      pc_load = ret_pc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      ret_pc_q    <= '0;
      guard_cnt_q <= '0;
      irq_count_q <= '0;
      err_q       <= 1'b0;
    end else begin
      if (reti && state_q != ISR) begin
        err_q <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (take) begin
            ret_pc_q <= pc_next;
            state_q  <= ISR;
            if (irq_count_q != '1) begin
              irq_count_q <= irq_count_q + CNT_W'(1);
            end
          end
        end
        ISR: begin
          if (reti) begin
            state_q     <= GUARD;
            guard_cnt_q <= GUARD_INIT;
          end
        end
        GUARD: begin
          if (guard_cnt_q == 4'd1) begin
            state_q <= IDLE;
          end
          guard_cnt_q <= guard_cnt_q - 4'd1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign irq_count    = irq_count_q;
  assign err_spurious = err_q;

endmodule

// File: tb/tb_irq_sequencer.sv
// Bench for irq_sequencer: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a behavioural model.
module tb_irq_sequencer;
  import cpu_pkg::*;

  localparam int unsigned PC_W      = 10;
  localparam int unsigned GUARD_CYC = 1;
  localparam int unsigned CNT_W     = 8;
  localparam int          CNT_MAX   = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             s_interrup = 1'b0;
  logic [PC_W-1:0]  dir = '0;
  logic             ie = 1'b0;
  logic [PC_W-1:0]  pc_next = '0;
  logic             reti = 1'b0;
  logic [PC_W-1:0]  pc_load;
  logic             fin;
  logic             in_isr;
  logic [CNT_W-1:0] irq_count;
  logic             err_spurious;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  // Model: "servicing" flag, number of main instructions still owed after a
  // return, saved return address, accepted count and sticky error.
  bit m_busy  = 1'b0;
  int m_owed  = 0;
  int m_ret   = 0;
  int m_cnt   = 0;
  bit m_err   = 1'b0;

  irq_sequencer #(
    .PC_W(PC_W),
    .GUARD_CYC(GUARD_CYC),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .s_interrup(s_interrup),
    .dir(dir),
    .ie(ie),
    .pc_next(pc_next),
    .reti(reti),
    .pc_load(pc_load),
    .fin(fin),
    .in_isr(in_isr),
    .irq_count(irq_count),
    .err_spurious(err_spurious)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit m_take();
    return !reset && !m_busy && m_owed == 0 && s_interrup && ie;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_busy = 1'b0; m_owed = 0; m_ret = 0; m_cnt = 0; m_err = 1'b0;
    end else begin
      if (reti && !m_busy) m_err = 1'b1;
      if (m_take()) begin
        m_busy = 1'b1;
        m_ret  = int'(pc_next);
        if (m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
      end else if (m_busy && reti) begin
        m_busy = 1'b0;
        m_owed = GUARD_CYC;
      end else if (m_owed > 0) begin
        m_owed = m_owed - 1;
      end
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      int exp_pc;
      bit exp_fin;
      exp_fin = !reset && m_busy && reti;
      exp_pc  = m_take() ? int'(dir) : (exp_fin ? m_ret : int'(pc_next));
      chk("mon_pc_load", int'(pc_load), exp_pc);
      chk("mon_fin", int'(fin), int'(exp_fin));
      chk("mon_in_isr", int'(in_isr), int'(!reset && m_busy));
      chk("mon_irq_count", int'(irq_count), m_cnt);
      chk("mon_err", int'(err_spurious), int'(m_err));
    end
  end

  task automatic drive(input bit r, input bit s, input int d, input bit e,
                       input int pc, input bit rt);
    @(posedge clk);
    #1;
    reset      = r;
    s_interrup = s;
    dir        = PC_W'(d);
    ie         = e;
    pc_next    = PC_W'(pc);
    reti       = rt;
    #1;
  endtask

  initial begin
    drive(1, 0, 0, 1, 5, 0);
    mon_en = 1'b1;
    drive(1, 0, 0, 1, 5, 0);
    chk("rst_in_isr", int'(in_isr), 0);
    chk("rst_fin", int'(fin), 0);
    chk("rst_pc_load", int'(pc_load), 5);
    drive(0, 0, 0, 1, 5, 0);
    chk("rst_count", int'(irq_count), 0);
    chk("rst_err", int'(err_spurious), 0);

    // Take vector 984 with zero-latency redirect.
    drive(0, 1, VEC_P0, 1, 5, 0);
    chk("take_pc", int'(pc_load), 984);
    chk("take_in_isr", int'(in_isr), 0);
    drive(0, 0, 0, 1, 100, 0);
    chk("isr_in_isr", int'(in_isr), 1);
    chk("isr_count", int'(irq_count), 1);
    chk("isr_pc", int'(pc_load), 100);
    // RETI with request still pending on vector 994.
    drive(0, 1, VEC_P1, 1, 990, 1);
    chk("reti_pc", int'(pc_load), 5);
    chk("reti_fin", int'(fin), 1);
    drive(0, 1, VEC_P1, 1, 6, 0);
    chk("guard_in_isr", int'(in_isr), 0);
    chk("guard_fin", int'(fin), 0);
    chk("guard_pc", int'(pc_load), 6);
    drive(0, 1, VEC_P1, 1, 7, 0);
    chk("retake_pc", int'(pc_load), 994);
    drive(0, 0, 0, 1, 200, 0);
    chk("retake_count", int'(irq_count), 2);
    drive(0, 0, 0, 1, 201, 1);
    chk("reti2_pc", int'(pc_load), 7);
    drive(0, 0, 0, 1, 8, 0);
    drive(0, 0, 0, 1, 9, 0);

    // Masked request for 10 cycles, then enable.
    for (int i = 0; i < 10; i++) begin
      drive(0, 1, VEC_P2, 0, 300 + i, 0);
      chk("masked_pc", int'(pc_load), 300 + i);
    end
    chk("masked_count", int'(irq_count), 2);
    drive(0, 1, VEC_P2, 1, 320, 0);
    chk("unmask_pc", int'(pc_load), 1004);
    drive(0, 0, 0, 0, 400, 0);
    chk("unmask_count", int'(irq_count), 3);

    // Reset in the middle of a routine, with reti present: no fin.
    drive(1, 0, 0, 1, 401, 1);
    chk("rst_isr_fin", int'(fin), 0);
    chk("rst_isr_pc", int'(pc_load), 401);
    drive(0, 0, 0, 1, 402, 0);
    chk("post_rst_in_isr", int'(in_isr), 0);
    chk("post_rst_count", int'(irq_count), 0);

    // Spurious RETI in IDLE, sticky until reset.
    drive(0, 0, 0, 1, 50, 1);
    chk("spur_pc", int'(pc_load), 50);
    chk("spur_fin", int'(fin), 0);
    drive(0, 0, 0, 1, 51, 0);
    chk("spur_err", int'(err_spurious), 1);
    drive(0, 1, VEC_P3, 1, 52, 0);
    chk("take3_pc", int'(pc_load), 1014);
    drive(0, 0, 0, 1, 600, 0);
    chk("take3_in_isr", int'(in_isr), 1);
    chk("take3_count", int'(irq_count), 1);
    chk("spur_err_hold", int'(err_spurious), 1);

    // Randomized traffic, rare resets later on.
    for (int i = 0; i < 6000; i++) begin
      drive(i > 4000 && $urandom_range(0, 299) == 0,
            $urandom_range(0, 1) == 1, int'($urandom_range(0, 1023)),
            $urandom_range(0, 3) != 0, int'($urandom_range(0, 1023)),
            $urandom_range(0, 7) == 0);
    end

    // Deterministic saturation of the accepted counter.
    drive(1, 0, 0, 1, 0, 0);
    for (int i = 0; i < CNT_MAX + 20; i++) begin
      drive(0, 1, VEC_P0, 1, 1, 0);
      drive(0, 0, 0, 1, 2, 1);
      drive(0, 0, 0, 1, 3, 0);
    end
    chk("sat_count", int'(irq_count), CNT_MAX);
    drive(0, 0, 0, 1, 3, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/irq_sequencer.md
Name: irq_sequencer

Overview:
- CPU-side counterpart of the interrupt manager. It consumes s_interrup/dir and redirects the monocycle PC to the vector.
- It saves the return address, tracks in-service state, and recognises RETI.
- On RETI it restores the PC and returns the one-cycle fin pulse that releases the manager.
- Sits between the PC-next mux and the PC register of the monocycle control unit.

Parameters:
- PC_W, 10, PC/vector width (matches 10-bit dir).
- GUARD_CYC, 1, main-program instructions guaranteed to execute after RETI before a new interrupt is accepted (1..15).
- CNT_W, 8, width of the accepted-interrupt counter.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- s_interrup  in  1  interrupt request from the manager (OR of the ports, level).
- dir  in  PC_W  vector address; valid only while s_interrup=1.
- ie  in  1  global interrupt enable.
- pc_next  in  PC_W  normal next PC computed by the CPU this cycle.
- reti  in  1  decoded return-from-interrupt instruction executing this cycle.
- pc_load  out  PC_W  value written to the PC register at the next edge.
- fin  out  1  end-of-service pulse to the manager.
- in_isr  out  1  high while executing a service routine.
- irq_count  out  CNT_W  saturating count of accepted interrupts.
- err_spurious  out  1  sticky: RETI seen outside a service routine.

Behaviour:
- States: IDLE, ISR, GUARD. Encoding comes from the package.
- Reset values (synchronous): state=IDLE, ret_pc=0, guard_cnt=0, irq_count=0, err_spurious=0. Outputs: fin=0, in_isr=0, pc_load=pc_next.
- take = (state==IDLE) & s_interrup & ie.
- IDLE:
  - If take: pc_load=dir (combinational, zero-latency redirect), so the first ISR instruction executes next cycle.
  - At the same edge: ret_pc<=pc_next, state<=ISR, irq_count<=irq_count+1, saturating at all-ones.
  - Otherwise pc_load=pc_next.
- ISR:
  - in_isr=1 and pc_load=pc_next.
  - s_interrup and dir are ignored; there is no nesting.
  - If reti: pc_load=ret_pc and fin=1 for exactly this cycle (combinational from reti & state==ISR). Then state<=GUARD and guard_cnt<=GUARD_CYC.
- GUARD:
  - pc_load=pc_next and fin=0.
  - guard_cnt decrements once per cycle. At guard_cnt==1 state<=IDLE, so GUARD_CYC main instructions always execute.
  - This guarantees forward progress when another port keeps s_interrup high.
- Simultaneous events:
  - reti in IDLE or GUARD: ignored for PC purposes; err_spurious<=1, cleared only by reset.
  - reti and take in the same IDLE cycle: take wins and err_spurious is set.
  - ie falling while in ISR: no effect on the current routine; it blocks only future takes.
- Reset mid-ISR: state returns to IDLE and fin is not emitted. The manager is reset by the same signal.
- ret_pc is held unchanged outside the take edge.
- No arithmetic on PC values. Widths are PC_W throughout, with no truncation.

Decomposition:
- Shared package (cpu_pkg): state typedef/localparams (IDLE/ISR/GUARD) and the vector constants 984/994/1004/1014, shared with the manager and the testbench.
- No sub-module is needed. The guard counter stays inline (under 20 lines).

Test Plan:
- After reset with ie=1 and pc_next=5: raise s_interrup with dir=984. Same cycle pc_load=984; next cycle in_isr=1, irq_count=1, ret_pc=5.
- In ISR, assert reti with pc_next=990. pc_load=5 and fin=1 for one cycle only. Next cycle in_isr=0 and state=GUARD.
- Keep s_interrup=1 with dir=994 across RETI, GUARD_CYC=1. Exactly one main instruction executes (pc_load=pc_next), then pc_load=994 and irq_count=2.
- With ie=0 and s_interrup=1, dir=1004 for 10 cycles: pc_load always equals pc_next and irq_count stays unchanged. Raise ie and the vector is taken the same cycle.
- Assert reti in IDLE: pc_load=pc_next, fin=0, and err_spurious=1 persists until reset.
- Assert reset mid-ISR: the next cycle shows in_isr=0, fin=0, irq_count=0. A new request with dir=1014 is accepted normally.
